regfile_wb: RTL and testbench

//   RV32I integer register file with a one-entry write-back staging register.

---
 rtl/rv_pkg.sv | 17 +
 rtl/rf_array.sv | 42 ++++
 rtl/regfile_wb.sv | 101 ++++++++++
 tb/tb_regfile_wb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the register file, ALU and decoder.
// Provides data/register widths, index/word types and the base opcodes.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011
  } opcode_e;

endpackage

// File: rtl/rf_array.sv
// Storage array for the register file: NREGS x XLEN words.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low clear of every entry
//   we_i       write enable
//   waddr_i    write address (writes to entry 0 are ignored)
//   wdata_i    write data
//   raddr0_i/raddr1_i/raddr2_i   combinational read addresses
//   rdata0_o/rdata1_o/rdata2_o   combinational read data
module rf_array
  import rv_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     we_i,
  input  reg_idx_t waddr_i,
  input  word_t    wdata_i,
  input  reg_idx_t raddr0_i,
  input  reg_idx_t raddr1_i,
  input  reg_idx_t raddr2_i,
  output word_t    rdata0_o,
  output word_t    rdata1_o,
  output word_t    rdata2_o
);

  word_t mem_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/regfile_wb.sv
// RV32I integer register file with a one-entry write-back staging register.
// Accepted write-backs are held in the stage for one cycle, then committed.
// Reads forward from the incoming write and the stage so dependent ops need
// no stall.
// Ports:
//   clk, rst_n            clock / synchronous active-low reset
//   rs1_addr, rs2_addr    operand read addresses
//   rdata1, rdata2        operand data (combinational, fully forwarded)
//   wb_valid, wb_rd, wb_data   write-back request
//   dbg_addr, dbg_data    architectural view: array plus stage, not incoming
//   wb_count              number of accepted (non-x0) write-backs, wrapping
module regfile_wb
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  reg_idx_t    rs1_addr,
  input  reg_idx_t    rs2_addr,
  output word_t       rdata1,
  output word_t       rdata2,
  input  logic        wb_valid,
  input  reg_idx_t    wb_rd,
  input  word_t       wb_data,
  input  reg_idx_t    dbg_addr,
  output word_t       dbg_data,
  output logic [31:0] wb_count
);

  logic        stage_valid_q, stage_valid_d;
  reg_idx_t    stage_rd_q,    stage_rd_d;
  word_t       stage_data_q,  stage_data_d;
  logic [31:0] wb_count_q,    wb_count_d;

  logic  accept;
  word_t arr_rs1, arr_rs2, arr_dbg;

  assign accept = wb_valid && (wb_rd != '0);

  always_comb begin
    stage_valid_d = accept;
    stage_rd_d    = stage_rd_q;
    stage_data_d  = stage_data_q;
    wb_count_d    = wb_count_q;
    if (accept) begin
      stage_rd_d   = wb_rd;
      stage_data_d = wb_data;
      wb_count_d   = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_rd_q    <= '0;
      stage_data_q  <= '0;
      wb_count_q    <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_rd_q    <= stage_rd_d;
      stage_data_q  <= stage_data_d;
      wb_count_q    <= wb_count_d;
    end
  end

  // The array's own reset clear takes priority over this commit, so a write
  // still in the stage when reset arrives is dropped.
  rf_array u_array (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .we_i     (stage_valid_q),
    .waddr_i  (stage_rd_q),
    .wdata_i  (stage_data_q),
    .raddr0_i (rs1_addr),
    .raddr1_i (rs2_addr),
    .raddr2_i (dbg_addr),
    .rdata0_o (arr_rs1),
    .rdata1_o (arr_rs2),
    .rdata2_o (arr_dbg)
  );

  // Youngest source wins: incoming write, then stage, then array.
  function automatic word_t fwd_read(reg_idx_t addr, word_t arr, logic use_incoming,
                                     logic wv, reg_idx_t wrd, word_t wdat,
                                     logic sv, reg_idx_t srd, word_t sdat);
    word_t r;
    r = arr;
    if (addr == '0)                        r = '0;
    else if (use_incoming && wv && wrd == addr) r = wdat;
    else if (sv && srd == addr)            r = sdat;
    return r;
  endfunction

  assign rdata1   = fwd_read(rs1_addr, arr_rs1, 1'b1, wb_valid, wb_rd, wb_data,
                             stage_valid_q, stage_rd_q, stage_data_q);
  assign rdata2   = fwd_read(rs2_addr, arr_rs2, 1'b1, wb_valid, wb_rd, wb_data,
                             stage_valid_q, stage_rd_q, stage_data_q);
  assign dbg_data = fwd_read(dbg_addr, arr_dbg, 1'b0, wb_valid, wb_rd, wb_data,
                             stage_valid_q, stage_rd_q, stage_data_q);
  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;
  import rv_pkg::*;

  logic        clk;
  logic        rst_n;
  reg_idx_t    rs1_addr, rs2_addr, wb_rd, dbg_addr;
  word_t       rdata1, rdata2, wb_data, dbg_data;
  logic        wb_valid;
  logic [31:0] wb_count;

  regfile_wb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_count (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel: 0 = rdata1, 1 = rdata2, 2 = dbg_data, 3 = wb_count
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples at the
  // falling edge in between.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        0:       act = rdata1;
        1:       act = rdata2;
        2:       act = dbg_data;
        default: act = wb_count;
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic idle_inputs();
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    dbg_addr = '0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;

    // 1: every register reads zero after reset
    expect_val("reset_count", 3, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = reg_idx_t'(i);
      expect_val($sformatf("reset_dbg_x%0d", i), 2, 32'd0);
      step();
    end

    // 2: single write, observed through each forwarding stage
    rs1_addr = 5'd5; dbg_addr = 5'd5;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    expect_val("t2_c0_incoming", 0, 32'h1234);
    expect_val("t2_c0_dbg_no_incoming", 2, 32'h0);
    step();
    idle_inputs();
    expect_val("t2_c1_stage", 0, 32'h1234);
    expect_val("t2_c1_dbg_stage", 2, 32'h1234);
    expect_val("t2_c1_count", 3, 32'd1);
    step();
    expect_val("t2_c2_array", 0, 32'h1234);
    expect_val("t2_c2_dbg", 2, 32'h1234);
    step();

    // 3: back-to-back writes to the same register
    rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA;
    expect_val("t3_c0_rs1", 0, 32'hA);
    expect_val("t3_c0_rs2", 1, 32'hA);
    step();
    wb_data = 32'hB;
    expect_val("t3_c1_rs1_incoming_wins", 0, 32'hB);
    expect_val("t3_c1_rs2_incoming_wins", 1, 32'hB);
    expect_val("t3_c1_dbg_stage_A", 2, 32'hA);
    step();
    idle_inputs();
    expect_val("t3_c2_rs1_stage_B", 0, 32'hB);
    expect_val("t3_c2_dbg_stage_B", 2, 32'hB);
    expect_val("t3_c2_count", 3, 32'd3);
    step();
    expect_val("t3_c3_array_B", 0, 32'hB);
    expect_val("t3_c3_dbg_array_B", 2, 32'hB);
    expect_val("t3_c3_x5_intact", 1, 32'h0);   // rs2 still 7? reset below
    rs2_addr = 5'd5;
    sb.pop_back();
    expect_val("t3_c3_x5_intact", 1, 32'h1234);
    step();

    // 4: writes to x0 are dropped
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    expect_val("t4_c0_rs1_x0", 0, 32'h0);
    expect_val("t4_c0_rs2_x0", 1, 32'h0);
    step();
    idle_inputs();
    expect_val("t4_c1_dbg_x0", 2, 32'h0);
    expect_val("t4_c1_count", 3, 32'd3);
    step();
    expect_val("t4_c2_dbg_x0", 2, 32'h0);
    step();

    // 5: staged write lost on reset; incoming write during reset ignored
    rs1_addr = 5'd3; rs2_addr = 5'd9; dbg_addr = 5'd3;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    expect_val("t5_c0_rs1", 0, 32'h55);
    step();
    rst_n = 1'b0;
    wb_rd = 5'd9; wb_data = 32'h77;
    expect_val("t5_rst_rs1_stage", 0, 32'h55);
    expect_val("t5_rst_rs2_incoming", 1, 32'h77);
    expect_val("t5_rst_dbg_stage", 2, 32'h55);
    step();
    rst_n = 1'b1;
    idle_inputs();
    expect_val("t5_after_rs1", 0, 32'h0);
    expect_val("t5_after_rs2", 1, 32'h0);
    expect_val("t5_after_count", 3, 32'd0);
    step();
    expect_val("t5_after2_rs1", 0, 32'h0);
    expect_val("t5_after2_dbg", 2, 32'h0);
    dbg_addr = 5'd5;
    step();
    expect_val("t5_x5_cleared", 2, 32'h0);
    step();

    // 6: counter wrap
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    expect_val("t6_preload", 3, 32'hFFFF_FFFF);
    rs1_addr = 5'd31;
    wb_valid = 1'b1; wb_rd = 5'd31; wb_data = 32'hCAFE_0001;
    expect_val("t6_rs1_incoming", 0, 32'hCAFE_0001);
    step();
    idle_inputs();
    expect_val("t6_wrapped", 3, 32'h0);
    step();
    expect_val("t6_x31", 0, 32'hCAFE_0001);
    step();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
